// File: rtl/insn_loader_pkg.sv
// Shared constants and FSM encoding for the byte-stream
// instruction memory loader.
package insn_loader_pkg;

  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam int INSN_W_DEF = 16;
  localparam int BYTES_PER_INSN = INSN_W_DEF / 8;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA,
    CSUM
  } state_t;

  function automatic int bytes_per_insn(input int insn_w);
    return insn_w / 8;
  endfunction

endpackage

// File: rtl/insn_loader_assembler.sv
// Byte-to-word shift register; word_valid pulses the cycle
// after the final (least significant) byte of a word arrives.
module insn_assembler
  import insn_loader_pkg::*;
#(
  parameter int INSN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              last,
  output logic [INSN_W-1:0] word,
  output logic              word_valid
);

  localparam int BPI = bytes_per_insn(INSN_W);

  logic [1:0]        cnt;
  logic [INSN_W-1:0] sr;
  logic [INSN_W-1:0] nxt;

  assign nxt  = (sr << 8) | INSN_W'(byte_data);
  assign last = (cnt == 2'(BPI - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        cnt <= '0;
        sr  <= '0;
      end else if (byte_valid) begin
        sr <= nxt;
        if (last) begin
          cnt        <= '0;
          word       <= nxt;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/insn_loader.sv
// Frame parser: SYNC, LEN, (LEN+1) MSB-first words, XOR checksum.
// Holds the CPU until a verified image has been written.
module insn_loader
  import insn_loader_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter int         INSN_W = 16,
  parameter logic [7:0] SYNC   = SYNC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INSN_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_t state;
  state_t state_nx;

  logic       acc;
  logic       sync_hit;
  logic       data_byte;
  logic       last;
  logic       word_valid;
  logic [8:0] left;
  logic [7:0] csum;

  logic [INSN_W-1:0] word;

  assign in_ready  = ~rst;
  assign acc       = in_valid & in_ready;
  assign sync_hit  = acc && state == IDLE && in_data == SYNC;
  assign data_byte = acc && state == DATA;
  assign mem_we    = word_valid;
  assign mem_wdata = word;

  insn_assembler #(
    .INSN_W(INSN_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (sync_hit),
    .byte_valid (data_byte),
    .byte_data  (in_data),
    .last       (last),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (sync_hit) state_nx = LEN;
      LEN:  if (acc) state_nx = DATA;
      DATA: if (data_byte && last && left == 9'd1)
              state_nx = CSUM;
      CSUM: if (acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      left      <= '0;
      csum      <= '0;
      mem_addr  <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      load_done <= 1'b0;
      if (sync_hit) begin
        cpu_hold <= 1'b1;
        load_err <= 1'b0;
        csum     <= '0;
        mem_addr <= '0;
      end
      if (acc && state == LEN) begin
        left <= {1'b0, in_data} + 9'd1;
        csum <= in_data;
      end
      if (data_byte) begin
        csum <= csum ^ in_data;
        if (last) left <= left - 9'd1;
      end
      if (acc && state == CSUM) begin
        if (in_data == csum) begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end
      // index advances after the write it addressed
      if (word_valid) mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_insn_loader.sv
// Scoreboard bench: stimulus pushes expected writes/events,
// a negedge monitor pops and compares them.
module tb_insn_loader;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } exp_t;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [7:0] din;

  logic        rdy0, we0, hold0, done0, err0;
  logic [7:0]  addr0;
  logic [15:0] wd0;
  logic        rdy1, we1, hold1, done1, err1;
  logic [1:0]  addr1;
  logic [15:0] wd1;

  exp_t q0[$];
  exp_t q1[$];

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int last_acc = 0;
  int tgt = 0;
  int gap_max = 0;
  logic ep0 = 1'b0;
  logic ep1 = 1'b0;

  insn_loader #(.ADDR_W(8), .INSN_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(din),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wd0), .cpu_hold(hold0), .load_done(done0),
    .load_err(err0)
  );

  insn_loader #(.ADDR_W(2), .INSN_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(din),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wd1), .cpu_hold(hold1), .load_done(done1),
    .load_err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic take(input int id, output exp_t e);
    e = '{kind: -1, addr: 0, data: 0, cyc: 0};
    if (id == 0) begin
      if (q0.size() > 0) e = q0.pop_front();
    end else if (q1.size() > 0) begin
      e = q1.pop_front();
    end
  endtask

  task automatic mon(input int id, input logic we,
                     input logic [7:0] a, input logic [15:0] d,
                     input logic done, input logic err,
                     input logic ep, input logic hold);
    exp_t e;
    if (we) begin
      take(id, e);
      chk($sformatf("d%0d_wr_kind", id), e.kind, K_WR);
      chk($sformatf("d%0d_wr_addr", id), {24'd0, a}, e.addr);
      chk($sformatf("d%0d_wr_data", id), {16'd0, d}, e.data);
      chk($sformatf("d%0d_wr_cyc", id), cyc, e.cyc);
    end
    if (done) begin
      take(id, e);
      chk($sformatf("d%0d_done_kind", id), e.kind, K_DONE);
      chk($sformatf("d%0d_done_cyc", id), cyc, e.cyc);
      chk($sformatf("d%0d_done_hold", id), {31'd0, hold}, 0);
    end
    if (err && !ep) begin
      take(id, e);
      chk($sformatf("d%0d_err_kind", id), e.kind, K_ERR);
      chk($sformatf("d%0d_err_cyc", id), cyc, e.cyc);
      chk($sformatf("d%0d_err_hold", id), {31'd0, hold}, 1);
    end
  endtask

  always @(negedge clk) begin
    mon(0, we0, addr0, wd0, done0, err0, ep0, hold0);
    mon(1, we1, {6'd0, addr1}, wd1, done1, err1, ep1, hold1);
    ep0 = err0;
    ep1 = err1;
  end

  task automatic push(input int kind, input int a, input int d);
    exp_t e;
    e = '{kind: kind, addr: a, data: d, cyc: last_acc};
    if (tgt == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    din = b;
    if (tgt == 0) v0 = 1'b1;
    else v1 = 1'b1;
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic good_frame();
    send(8'hA5); send(8'h01);
    send(8'h12); send(8'h34); push(K_WR, 0, 16'h1234);
    send(8'h56); send(8'h78); push(K_WR, 1, 16'h5678);
    send(8'h09); push(K_DONE, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    din = 8'h00;
    #1;
    chk("rst_ready", {31'd0, rdy0}, 0);
    chk("rst_hold", {31'd0, hold0}, 1);
    chk("rst_addr", {24'd0, addr0}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    chk("idle_ready", {31'd0, rdy0}, 1);
    chk("idle_hold", {31'd0, hold0}, 1);
    chk("idle_done", {31'd0, done0}, 0);
    chk("idle_err", {31'd0, err0}, 0);

    send(8'h00); send(8'h3C);
    good_frame();
    idle(2);
    chk("post_done_hold", {31'd0, hold0}, 0);

    send(8'hA5);
    chk("sync_hold", {31'd0, hold0}, 1);
    send(8'h01);
    send(8'h12); send(8'h34); push(K_WR, 0, 16'h1234);
    send(8'h56); send(8'h78); push(K_WR, 1, 16'h5678);
    send(8'h08); push(K_ERR, 0, 0);
    idle(2);
    chk("bad_err", {31'd0, err0}, 1);
    chk("bad_hold", {31'd0, hold0}, 1);
    send(8'hA5);
    chk("resync_err_clr", {31'd0, err0}, 0);
    send(8'h01);
    send(8'h12); send(8'h34); push(K_WR, 0, 16'h1234);
    send(8'h56); send(8'h78); push(K_WR, 1, 16'h5678);
    send(8'h09); push(K_DONE, 0, 0);
    idle(2);

    gap_max = 2;
    send(8'hA5); send(8'h00);
    send(8'hA5); send(8'h5A); push(K_WR, 0, 16'hA55A);
    send(8'hFF); push(K_DONE, 0, 0);
    gap_max = 0;
    idle(2);

    send(8'hA5); send(8'h01);
    send(8'h12); send(8'h34); push(K_WR, 0, 16'h1234);
    send(8'h56);
    #3 rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, we0}, 0);
    chk("arst_hold", {31'd0, hold0}, 1);
    chk("arst_ready", {31'd0, rdy0}, 0);
    chk("arst_addr", {24'd0, addr0}, 0);
    chk("arst_wdata", {16'd0, wd0}, 0);
    chk("arst_err", {31'd0, err0}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    good_frame();
    idle(2);

    tgt = 1;
    send(8'hA5); send(8'h04);
    send(8'h00); send(8'h01); push(K_WR, 0, 16'h0001);
    send(8'h00); send(8'h02); push(K_WR, 1, 16'h0002);
    send(8'h00); send(8'h03); push(K_WR, 2, 16'h0003);
    send(8'h00); send(8'h04); push(K_WR, 3, 16'h0004);
    send(8'h00); send(8'h05); push(K_WR, 0, 16'h0005);
    send(8'h05); push(K_DONE, 0, 0);
    tgt = 0;

    idle(6);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
